seq_somador16: RTL

SEQ_SOMADOR16 -- requirements
Module: seq_somador16

---
 rtl/seq_somador16_pkg.sv | 14 +
 rtl/somador4B.sv | 27 ++
 rtl/seq_somador16.sv | 134 +++++++++++++
 3 files changed

// File: rtl/seq_somador16_pkg.sv
// seq_somador16_pkg: shared definitions for the sequential nibble-serial adder.
//   state_t  - FSM state encoding (IDLE=0, RUN=1, DONE=2, 2 bits)
//   SLICE_W  - width of the single adder slice
package seq_somador16_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_t;

endpackage

// File: rtl/somador4B.sv
// somador4B: 4-bit ripple-carry adder slice.
//   a, b  - 4-bit operands
//   cin   - carry-in
//   s     - 4-bit sum
//   cout  - carry-out of bit 3
module somador4B
    import seq_somador16_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
        assign s[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[SLICE_W];

endmodule

// File: rtl/seq_somador16.sv
// seq_somador16: computes {cout,s} = a + b + cin with one 4-bit adder slice,
// time-multiplexed over NIBBLES cycles, least significant nibble first.
//   clk    - clock, rising edge
//   rst_n  - synchronous active-low reset
//   start  - request an addition (sampled only when idle)
//   a, b   - operands, captured on an accepted start
//   cin    - carry-in, captured on an accepted start
//   sub    - (only with SEQ_SOMADOR_SUB_EN) 1: a - b, cin ignored
//   busy   - operation in progress (RUN or DONE)
//   done   - one-cycle pulse, s/cout valid from this cycle
//   s      - registered sum, partial nibbles visible while running
//   cout   - registered carry-out of the top nibble (1 = no borrow when subtracting)
// Optional feature macro: SEQ_SOMADOR_SUB_EN (adds the sub input).
module seq_somador16
    import seq_somador16_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [SLICE_W*NIBBLES-1:0] a,
    input  logic [SLICE_W*NIBBLES-1:0] b,
    input  logic                       cin,
`ifdef SEQ_SOMADOR_SUB_EN
    input  logic                       sub,
`endif
    output logic                       busy,
    output logic                       done,
    output logic [SLICE_W*NIBBLES-1:0] s,
    output logic                       cout
);

    localparam int unsigned W     = SLICE_W * NIBBLES;
    localparam int unsigned CNT_W = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     s_q, s_d;
    logic             cout_q, cout_d;

    logic [SLICE_W-1:0] slice_s;
    logic               slice_co;

    // Operand registers shift right each slice, so the adder always sees nibble 0.
    somador4B u_slice (
        .a    (a_q[SLICE_W-1:0]),
        .b    (b_q[SLICE_W-1:0]),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_co)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
`ifdef SEQ_SOMADOR_SUB_EN
                    // Two's complement subtraction: invert b, inject carry of 1.
                    if (sub) begin
                        b_d     = ~b;
                        carry_d = 1'b1;
                    end
`endif
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int i = 0; i < int'(NIBBLES); i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        s_d[i*SLICE_W +: SLICE_W] = slice_s;
                    end
                end
                carry_d = slice_co;
                a_d     = a_q >> SLICE_W;
                b_d     = b_q >> SLICE_W;
                if (cnt_q == LAST) begin
                    cout_d  = slice_co;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = (state_q == StDone);
    assign s    = s_q;
    assign cout = cout_q;

endmodule
